// File: rtl/mem_resp_pkg.sv
// Shared types and widths for the mem_responder slice: FSM state encoding,
// bus widths and the byte-address to word-index helper.
package mem_resp_pkg;

    localparam int unsigned DATA_W = 32;
    localparam int unsigned BE_W   = 4;
    localparam int unsigned CNT_W  = 4;

    typedef enum logic {
        IDLE = 1'b0,
        WAIT = 1'b1
    } state_e;

    // Modular offset from the window base, dropped to a word index.
    function automatic logic [29:0] word_index(input logic [31:0] addr,
                                               input logic [31:0] base);
        return 30'((addr - base) >> 2);
    endfunction

endpackage

// File: rtl/mem_resp_ram.sv
// Single-port synchronous RAM with per-byte write enables and a registered
// read port; the read register only updates on read accesses.
module mem_resp_ram
    import mem_resp_pkg::*;
#(
    parameter int unsigned WORDS = 1024,
    parameter int unsigned AW    = $clog2(WORDS)
) (
    input  logic              clk_i,
    input  logic              en_i,
    input  logic              we_i,
    input  logic [BE_W-1:0]   be_i,
    input  logic [AW-1:0]     addr_i,
    input  logic [DATA_W-1:0] wdata_i,
    output logic [DATA_W-1:0] rdata_o
);

    logic [DATA_W-1:0] mem_q [WORDS];
    logic [DATA_W-1:0] rdata_q;

    always_ff @(posedge clk_i) begin
        if (en_i) begin
            if (we_i) begin
                for (int unsigned b = 0; b < BE_W; b++) begin
                    if (be_i[b]) begin
                        mem_q[addr_i][8*b +: 8] <= wdata_i[8*b +: 8];
                    end
                end
            end else begin
                rdata_q <= mem_q[addr_i];
            end
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/mem_responder.sv
// Request/grant memory responder with optional stall cycles before each grant.
// Define MEM_RESP_ERR_EN to add err_o and out-of-range error responses.
module mem_responder
    import mem_resp_pkg::*;
#(
    parameter int unsigned MEM_WORDS   = 1024,
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
    parameter int unsigned WAIT_CYCLES = 0
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              req_i,
    output logic              gnt_o,
    output logic              rvalid_o,
    input  logic              we_i,
    input  logic [BE_W-1:0]   be_i,
    input  logic [31:0]       addr_i,
    input  logic [DATA_W-1:0] wdata_i,
`ifdef MEM_RESP_ERR_EN
    output logic              err_o,
`endif
    output logic [DATA_W-1:0] rdata_o
);

    localparam int unsigned AW = $clog2(MEM_WORDS);
    localparam logic [CNT_W-1:0] WAIT_LOAD =
        (WAIT_CYCLES == 0) ? '0 : CNT_W'(WAIT_CYCLES - 1);

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              gnt;
    logic              rvalid_q;
    logic              rd_q;
    logic [DATA_W-1:0] hold_q;
    logic [DATA_W-1:0] ram_rdata;
    logic [DATA_W-1:0] resp_data;
    logic [29:0]       word;
    logic [AW-1:0]     ram_idx;
    logic              in_range;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        gnt     = 1'b0;
        case (state_q)
            IDLE: begin
                if (req_i) begin
                    if (WAIT_CYCLES == 0) begin
                        gnt = 1'b1;
                    end else begin
                        cnt_d   = WAIT_LOAD;
                        state_d = WAIT;
                    end
                end
            end
            WAIT: begin
                if (!req_i) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else if (cnt_q == '0) begin
                    gnt     = 1'b1;
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
        // A grant in a reset cycle must never produce an access or response.
        if (rst_i) begin
            gnt = 1'b0;
        end
    end

    assign word    = word_index(addr_i, BASE_ADDR);
    assign ram_idx = word[AW-1:0];

`ifdef MEM_RESP_ERR_EN
    logic err_q;
    assign in_range = ({2'b00, word} < MEM_WORDS);
`else
    logic unused_word_hi;
    assign in_range       = 1'b1;
    assign unused_word_hi = ^(word >> AW);
`endif

    mem_resp_ram #(
        .WORDS (MEM_WORDS),
        .AW    (AW)
    ) u_ram (
        .clk_i   (clk_i),
        .en_i    (gnt & in_range),
        .we_i    (we_i),
        .be_i    (be_i),
        .addr_i  (ram_idx),
        .wdata_i (wdata_i),
        .rdata_o (ram_rdata)
    );

    assign resp_data = rd_q ? ram_rdata : '0;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            rvalid_q <= 1'b0;
            rd_q     <= 1'b0;
            hold_q   <= '0;
`ifdef MEM_RESP_ERR_EN
            err_q    <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            rvalid_q <= gnt;
            rd_q     <= gnt & ~we_i & in_range;
`ifdef MEM_RESP_ERR_EN
            err_q    <= gnt & ~in_range;
`endif
            if (rvalid_q) begin
                hold_q <= resp_data;
            end
        end
    end

    assign gnt_o    = gnt;
    assign rvalid_o = rvalid_q & ~rst_i;
    assign rdata_o  = rst_i ? '0 : (rvalid_q ? resp_data : hold_q);
`ifdef MEM_RESP_ERR_EN
    assign err_o    = err_q & rvalid_q & ~rst_i;
`endif

endmodule

// File: tb/tb_mem_responder.sv
// Directed bench for mem_responder: a zero-wait instance driven from a vector
// table plus hand sequences, and a three-stall instance for grant timing.
module tb_mem_responder;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic        req0, gnt0, rvalid0, we0;
    logic [3:0]  be0;
    logic [31:0] addr0, wdata0, rdata0;
    logic        req1, gnt1, rvalid1, we1;
    logic [3:0]  be1;
    logic [31:0] addr1, wdata1, rdata1;
`ifdef MEM_RESP_ERR_EN
    logic        err0, err1;
`endif

    int total = 0;
    int bad   = 0;

    mem_responder #(
        .MEM_WORDS   (1024),
        .BASE_ADDR   (32'h0000_0000),
        .WAIT_CYCLES (0)
    ) dut0 (
        .clk_i    (clk),
        .rst_i    (rst),
        .req_i    (req0),
        .gnt_o    (gnt0),
        .rvalid_o (rvalid0),
        .we_i     (we0),
        .be_i     (be0),
        .addr_i   (addr0),
        .wdata_i  (wdata0),
`ifdef MEM_RESP_ERR_EN
        .err_o    (err0),
`endif
        .rdata_o  (rdata0)
    );

    mem_responder #(
        .MEM_WORDS   (16),
        .BASE_ADDR   (32'h1000_0000),
        .WAIT_CYCLES (3)
    ) dut1 (
        .clk_i    (clk),
        .rst_i    (rst),
        .req_i    (req1),
        .gnt_o    (gnt1),
        .rvalid_o (rvalid1),
        .we_i     (we1),
        .be_i     (be1),
        .addr_i   (addr1),
        .wdata_i  (wdata1),
`ifdef MEM_RESP_ERR_EN
        .err_o    (err1),
`endif
        .rdata_o  (rdata1)
    );

    typedef struct {
        logic        we;
        logic [3:0]  be;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] exp_rdata;
        logic        exp_err;
    } vec_t;

    vec_t vecs[10];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    // One zero-wait access: grant in the request cycle, response one cycle
    // later, then rdata must hold with rvalid low.
    task automatic apply0(input vec_t v, input string tag);
        @(negedge clk);
        req0 = 1'b1; we0 = v.we; be0 = v.be; addr0 = v.addr; wdata0 = v.wdata;
        #1 chk({tag, "_gnt"}, {31'd0, gnt0}, 32'd1);
        @(posedge clk);
        #1 req0 = 1'b0;
        chk({tag, "_rvalid"}, {31'd0, rvalid0}, 32'd1);
        chk({tag, "_rdata"}, rdata0, v.exp_rdata);
`ifdef MEM_RESP_ERR_EN
        chk({tag, "_err"}, {31'd0, err0}, {31'd0, v.exp_err});
`endif
        @(posedge clk);
        #1 chk({tag, "_rvalid_low"}, {31'd0, rvalid0}, 32'd0);
        chk({tag, "_rdata_hold"}, rdata0, v.exp_rdata);
    endtask

    // Held-request access on the three-stall instance; grant expected on
    // the fourth cycle of req.
    task automatic run1(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [31:0] exp, input string tag);
        int got;
        got = 0;
        @(negedge clk);
        req1 = 1'b1; we1 = we; be1 = 4'hF; addr1 = addr; wdata1 = wdata;
        for (int k = 1; k <= 10; k++) begin
            #1;
            if (gnt1) begin
                got = k;
                break;
            end
            @(negedge clk);
        end
        chk({tag, "_gnt_cycle"}, 32'(got), 32'd4);
        if (got != 0) begin
            @(posedge clk);
            #1 req1 = 1'b0;
            chk({tag, "_rvalid"}, {31'd0, rvalid1}, 32'd1);
            chk({tag, "_rdata"}, rdata1, exp);
            @(posedge clk);
            #1 chk({tag, "_rvalid_low"}, {31'd0, rvalid1}, 32'd0);
        end else begin
            req1 = 1'b0;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        vecs[0] = '{1'b1, 4'hF, 32'h10,  32'hDEAD_BEEF, 32'h0,         1'b0};
        vecs[1] = '{1'b0, 4'h0, 32'h10,  32'h0,         32'hDEAD_BEEF, 1'b0};
        vecs[2] = '{1'b1, 4'h5, 32'h10,  32'h1122_3344, 32'h0,         1'b0};
        vecs[3] = '{1'b0, 4'hF, 32'h10,  32'h0,         32'hDE22_BE44, 1'b0};
        vecs[4] = '{1'b1, 4'h0, 32'h10,  32'hFFFF_FFFF, 32'h0,         1'b0};
        vecs[5] = '{1'b0, 4'h0, 32'h13,  32'h0,         32'hDE22_BE44, 1'b0};
        vecs[6] = '{1'b1, 4'hF, 32'h0,   32'hA5A5_0001, 32'h0,         1'b0};
`ifdef MEM_RESP_ERR_EN
        vecs[7] = '{1'b0, 4'hF, 32'h1000, 32'h0,        32'h0,         1'b1};
`else
        vecs[7] = '{1'b0, 4'hF, 32'h1000, 32'h0,        32'hA5A5_0001, 1'b0};
`endif
        vecs[8] = '{1'b1, 4'h3, 32'hFFC, 32'hAAAA_BBBB, 32'h0,         1'b0};
        vecs[9] = '{1'b0, 4'h0, 32'hFFC, 32'h0,         32'h1234_BBBB, 1'b0};

        rst = 1'b1;
        req0 = 1'b1; we0 = 1'b0; be0 = 4'hF; addr0 = '0; wdata0 = '0;
        req1 = 1'b1; we1 = 1'b0; be1 = 4'hF; addr1 = 32'h1000_0000; wdata1 = '0;
        @(posedge clk);
        @(posedge clk);
        #1;
        chk("rst_gnt0", {31'd0, gnt0}, 32'd0);
        chk("rst_rvalid0", {31'd0, rvalid0}, 32'd0);
        chk("rst_rdata0", rdata0, 32'd0);
        chk("rst_gnt1", {31'd0, gnt1}, 32'd0);
        chk("rst_rvalid1", {31'd0, rvalid1}, 32'd0);
        @(negedge clk);
        rst = 1'b0; req0 = 1'b0; req1 = 1'b0;

        // Known contents before the partial write in the table.
        apply0('{1'b1, 4'hF, 32'hFFC, 32'h1234_5678, 32'h0, 1'b0}, "pre_ffc");
        for (int i = 0; i < 10; i++) begin
            apply0(vecs[i], $sformatf("vec%0d", i));
        end

        for (int i = 0; i < 8; i++) begin
            apply0('{1'b1, 4'hF, 32'h100 + 32'(4*i), 32'h5000_0000 + 32'(17*i), 32'h0, 1'b0},
                   $sformatf("b2b_wr%0d", i));
        end
        @(negedge clk);
        req0 = 1'b1; we0 = 1'b0; be0 = 4'h0; addr0 = 32'h100;
        for (int i = 0; i < 8; i++) begin
            #1 chk($sformatf("b2b_gnt%0d", i), {31'd0, gnt0}, 32'd1);
            @(posedge clk);
            #1;
            if (i == 7) req0 = 1'b0;
            else addr0 = 32'h100 + 32'(4*(i+1));
            chk($sformatf("b2b_rvalid%0d", i), {31'd0, rvalid0}, 32'd1);
            chk($sformatf("b2b_rdata%0d", i), rdata0, 32'h5000_0000 + 32'(17*i));
        end
        @(posedge clk);
        #1 chk("b2b_rvalid_end", {31'd0, rvalid0}, 32'd0);

        // Reset lands in the cycle the write response would be valid.
        @(negedge clk);
        req0 = 1'b1; we0 = 1'b1; be0 = 4'hF; addr0 = 32'h20; wdata0 = 32'hCAFE_F00D;
        #1 chk("rstw_gnt", {31'd0, gnt0}, 32'd1);
        @(posedge clk);
        #1 req0 = 1'b0; rst = 1'b1;
        #1 chk("rstw_rvalid", {31'd0, rvalid0}, 32'd0);
        chk("rstw_rdata", rdata0, 32'd0);
        @(posedge clk);
        #1 rst = 1'b0;
        chk("rstw_rvalid_after", {31'd0, rvalid0}, 32'd0);
        apply0('{1'b0, 4'hF, 32'h20, 32'h0, 32'hCAFE_F00D, 1'b0}, "rstw_rd20");
        apply0('{1'b0, 4'hF, 32'h10, 32'h0, 32'hDE22_BE44, 1'b0}, "rstw_rd10");

        run1(1'b1, 32'h1000_0008, 32'h0BAD_CAFE, 32'h0, "w3_wr");
        run1(1'b0, 32'h1000_0008, 32'h0,         32'h0BAD_CAFE, "w3_rd");

        begin
            int act;
            act = 0;
            @(negedge clk);
            req1 = 1'b1; we1 = 1'b0; addr1 = 32'h1000_0008;
            #1 chk("drop_first_gnt", {31'd0, gnt1}, 32'd0);
            @(negedge clk);
            req1 = 1'b0;
            for (int k = 0; k < 6; k++) begin
                #1;
                if (gnt1 || rvalid1) act++;
                @(negedge clk);
            end
            chk("drop_activity", 32'(act), 32'd0);
        end
        run1(1'b0, 32'h1000_0008, 32'h0, 32'h0BAD_CAFE, "w3_after_drop");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mem_responder.md
MEM_RESPONDER -- requirements
Module: mem_responder

Interface
REQ-001 SHALL have parameter MEM_WORDS, default 1024, meaning RAM depth in 32-bit words (power of two, >=2).
REQ-002 SHALL have parameter BASE_ADDR, default 32'h0000_0000, meaning byte address that maps to word 0.
REQ-003 SHALL have parameter WAIT_CYCLES, default 0, meaning number of stall cycles inserted before each grant (0..15).
REQ-004 SHALL have port clk_i, input, 1 bit, the single clock; all state updates on its rising edge.
REQ-005 SHALL have port rst_i, input, 1 bit, the reset, which is synchronous and active-high.
REQ-006 SHALL have port req_i, input, 1 bit, initiator request, held high until granted.
REQ-007 SHALL have port gnt_o, output, 1 bit, grant; the request is accepted in the cycle req_i and gnt_o are both high.
REQ-008 SHALL have port rvalid_o, output, 1 bit, response valid, a single-cycle pulse per accepted request.
REQ-009 SHALL have port we_i, input, 1 bit, 1 = write, 0 = read.
REQ-010 SHALL have port be_i, input, 4 bits, byte enables; bit n selects wdata_i[8n+7:8n].
REQ-011 SHALL have port addr_i, input, 32 bits, byte address; bits [1:0] ignored.
REQ-012 SHALL have port wdata_i, input, 32 bits, write data.
REQ-013 SHALL have port rdata_o, output, 32 bits, read data, valid while rvalid_o is high.
REQ-014 SHALL have port err_o, output, 1 bit, error response flag, present only when MEM_RESP_ERR_EN is defined.

Function
REQ-015 SHALL compute word index = (addr_i - BASE_ADDR) >> 2, 32-bit modular subtraction.
REQ-016 SHALL implement FSM states IDLE and WAIT with a 4-bit stall counter.
REQ-017 In IDLE with req_i=1: if WAIT_CYCLES=0, SHALL assert gnt_o combinationally in the same cycle; otherwise SHALL load the counter with WAIT_CYCLES-1, move to WAIT and keep gnt_o=0.
REQ-018 In WAIT: SHALL decrement the counter each cycle; when it is 0 and req_i=1, SHALL assert gnt_o and return to IDLE.
REQ-019 If req_i drops while in WAIT, SHALL return to IDLE with no access and no response.
REQ-020 On acceptance SHALL perform the RAM access in that cycle and assert rvalid_o exactly one cycle later; read-to-rvalid latency is 1 cycle after grant.
REQ-021 Read: rdata_o SHALL equal the full word stored at the index, with be_i ignored.
REQ-022 Write: SHALL update only the byte lanes whose be_i bit is set; be_i=4'b0000 SHALL leave memory unchanged but still respond; rdata_o SHALL be 0 on write responses.
REQ-023 rvalid_o and gnt_o SHALL be allowed high in the same cycle, giving back-to-back throughput of 1 access per cycle when WAIT_CYCLES=0.
REQ-024 A read in the cycle after a write to the same word SHALL return the newly written data.
REQ-025 rdata_o SHALL hold its last value when rvalid_o=0.

Reset
REQ-026 While rst_i=1: state SHALL be IDLE, counter 0, gnt_o=0, rvalid_o=0, rdata_o=0, err_o=0.
REQ-027 Reset mid-operation SHALL drop any pending stall or response; no rvalid_o SHALL follow a grant issued in the cycle rst_i is sampled high.
REQ-028 Reset SHALL NOT clear RAM contents.

Configuration
REQ-029 With macro MEM_RESP_ERR_EN defined: an index >= MEM_WORDS SHALL be granted normally, SHALL NOT access the RAM, and SHALL respond with err_o=1, rdata_o=0; err_o SHALL be 0 on all other responses.
REQ-030 Without MEM_RESP_ERR_EN: err_o SHALL be absent and the index SHALL wrap modulo MEM_WORDS.

Structure
REQ-031 Package mem_resp_pkg SHALL hold the FSM state enum (IDLE, WAIT), the data width (32), the byte-enable width (4) and the counter width (4).
REQ-032 SHALL instantiate one sub-module, mem_resp_ram: single-port synchronous RAM with per-byte write enables and registered read data.

Verification
REQ-033 WAIT_CYCLES=0: write 32'hDEADBEEF to 0x10 with be=4'hF, then read 0x10 -> gnt in the request cycle, rvalid 1 cycle later, rdata=32'hDEADBEEF.
REQ-034 Partial write: be=4'b0101, wdata 32'h11223344 over 32'hDEADBEEF, then read -> rdata=32'hDE22BE44.
REQ-035 WAIT_CYCLES=3: read request held -> gnt on the 4th cycle of req_i, rvalid on the 5th; req_i dropped after 1 cycle -> no gnt, no rvalid.
REQ-036 Back-to-back: 8 reads on consecutive cycles with WAIT_CYCLES=0 -> 8 rvalid pulses on consecutive cycles, data in order.
REQ-037 With MEM_RESP_ERR_EN, MEM_WORDS=1024: read of BASE_ADDR+0x1000 -> err_o=1, rdata=0; without the macro the same address returns word 0.
REQ-038 rst_i asserted the cycle after a grant -> rvalid_o stays 0; memory holds previous values after reset.
